// File: rtl/mmio_timeout_bridge_if.sv
// Memory-mapped register bus: one read channel and one write channel, each a
// level req held until a single-cycle ack.
interface mmio_if #(
  parameter int INDEX_WIDTH = 16,
  parameter int DATA_WIDTH  = 32
);
  logic                   read_req;
  logic [INDEX_WIDTH-1:0] read_index;
  logic                   read_ack;
  logic [DATA_WIDTH-1:0]  read_data;

  logic                   write_req;
  logic [INDEX_WIDTH-1:0] write_index;
  logic [DATA_WIDTH-1:0]  write_data;
  logic                   write_ack;

  modport host (
    output read_req, read_index, write_req, write_index, write_data,
    input  read_ack, read_data, write_ack
  );

  modport device (
    input  read_req, read_index, write_req, write_index, write_data,
    output read_ack, read_data, write_ack
  );
endinterface

// File: rtl/mmio_timeout_bridge.sv
// Registered single-outstanding MMIO stage with a bounded downstream wait;
// unacknowledged transactions are force-completed and logged as timeouts.
module mmio_timeout_bridge #(
  parameter int          TIMEOUT_CYCLES       = 64,
  parameter logic [31:0] ERROR_DATA           = 32'hDEAD_BEEF,
  parameter int          TIA_MMIO_INDEX_WIDTH = 16,
  parameter int          TIA_MMIO_DATA_WIDTH  = 32
) (
  input  logic                            clock,
  input  logic                            reset,
  mmio_if.device                          host_interface,
  mmio_if.host                            device_interface,
  input  logic                            clear_error,
  output logic                            timeout_error,
  output logic                            timeout_is_write,
  output logic [TIA_MMIO_INDEX_WIDTH-1:0] timeout_index
);

  localparam int IW = TIA_MMIO_INDEX_WIDTH;
  localparam int DW = TIA_MMIO_DATA_WIDTH;
  localparam int CW = (TIMEOUT_CYCLES < 1) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [CW-1:0] CNT_SAT  = {CW{1'b1}};
  localparam logic [DW-1:0] ERR_WORD = DW'(ERROR_DATA);

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    READ_WAIT  = 3'd1,
    WRITE_WAIT = 3'd2,
    RESPOND    = 3'd3,
    RELEASE    = 3'd4
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          is_write_q, is_write_d;
  logic [IW-1:0] index_q, index_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic [DW-1:0] rdata_q, rdata_d;
  logic          err_q, err_d;
  logic          err_wr_q, err_wr_d;
  logic [IW-1:0] err_idx_q, err_idx_d;

  logic          dev_rreq_q, dev_rreq_d;
  logic          dev_wreq_q, dev_wreq_d;
  logic          host_rack_q, host_rack_d;
  logic          host_wack_q, host_wack_d;

  logic          wait_ack;
  logic          active_req;

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      is_write_q  <= 1'b0;
      index_q     <= '0;
      wdata_q     <= '0;
      rdata_q     <= '0;
      err_q       <= 1'b0;
      err_wr_q    <= 1'b0;
      err_idx_q   <= '0;
      dev_rreq_q  <= 1'b0;
      dev_wreq_q  <= 1'b0;
      host_rack_q <= 1'b0;
      host_wack_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      is_write_q  <= is_write_d;
      index_q     <= index_d;
      wdata_q     <= wdata_d;
      rdata_q     <= rdata_d;
      err_q       <= err_d;
      err_wr_q    <= err_wr_d;
      err_idx_q   <= err_idx_d;
      dev_rreq_q  <= dev_rreq_d;
      dev_wreq_q  <= dev_wreq_d;
      host_rack_q <= host_rack_d;
      host_wack_q <= host_wack_d;
    end
  end

  // Only the ack of the channel actually in flight may complete the wait.
  assign wait_ack   = (state_q == WRITE_WAIT) ? device_interface.write_ack
                                              : device_interface.read_ack;
  assign active_req = is_write_q ? host_interface.write_req
                                 : host_interface.read_req;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    is_write_d = is_write_q;
    index_d    = index_q;
    wdata_d    = wdata_q;
    rdata_d    = rdata_q;
    err_d      = err_q;
    err_wr_d   = err_wr_q;
    err_idx_d  = err_idx_q;

    if (clear_error) begin
      err_d = 1'b0;
    end

    unique case (state_q)
      IDLE: begin
        if (host_interface.read_req) begin
          state_d    = READ_WAIT;
          is_write_d = 1'b0;
          index_d    = host_interface.read_index;
          cnt_d      = '0;
        end else if (host_interface.write_req) begin
          state_d    = WRITE_WAIT;
          is_write_d = 1'b1;
          index_d    = host_interface.write_index;
          wdata_d    = host_interface.write_data;
          cnt_d      = '0;
        end
      end

      READ_WAIT, WRITE_WAIT: begin
        if (wait_ack) begin
          state_d = RESPOND;
          if (!is_write_q) begin
            rdata_d = device_interface.read_data;
          end
        end else if (cnt_q == CNT_LAST) begin
          // Expiry overrides a simultaneous clear_error so the event is not lost.
          state_d   = RESPOND;
          err_d     = 1'b1;
          err_wr_d  = is_write_q;
          err_idx_d = index_q;
          if (!is_write_q) begin
            rdata_d = ERR_WORD;
          end
        end else if (cnt_q != CNT_SAT) begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      RESPOND: begin
        state_d = RELEASE;
      end

      RELEASE: begin
        if (!active_req) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Output flops are loaded from the next state so every handshake line is a
  // register yet still lines up with the state it belongs to.
  always_comb begin
    dev_rreq_d  = (state_d == READ_WAIT);
    dev_wreq_d  = (state_d == WRITE_WAIT);
    host_rack_d = (state_d == RESPOND) && !is_write_d;
    host_wack_d = (state_d == RESPOND) &&  is_write_d;
  end

  assign device_interface.read_req    = dev_rreq_q;
  assign device_interface.read_index  = index_q;
  assign device_interface.write_req   = dev_wreq_q;
  assign device_interface.write_index = index_q;
  assign device_interface.write_data  = wdata_q;

  assign host_interface.read_ack      = host_rack_q;
  assign host_interface.read_data     = rdata_q;
  assign host_interface.write_ack     = host_wack_q;

  assign timeout_error    = err_q;
  assign timeout_is_write = err_wr_q;
  assign timeout_index    = err_idx_q;

endmodule

// File: tb/tb_mmio_timeout_bridge.sv
// Directed bench for mmio_timeout_bridge: a small downstream responder with a
// programmable ack delay, and one task per scenario.
module tb_mmio_timeout_bridge;

  localparam int IW = 16;
  localparam int DW = 32;
  localparam int TO = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          clear_error = 1'b0;
  logic          timeout_error;
  logic          timeout_is_write;
  logic [IW-1:0] timeout_index;

  mmio_if #(.INDEX_WIDTH(IW), .DATA_WIDTH(DW)) host_bus ();
  mmio_if #(.INDEX_WIDTH(IW), .DATA_WIDTH(DW)) dev_bus ();

  always #5 clk = ~clk;

  mmio_timeout_bridge #(
    .TIMEOUT_CYCLES       (TO),
    .ERROR_DATA           (32'hDEAD_BEEF),
    .TIA_MMIO_INDEX_WIDTH (IW),
    .TIA_MMIO_DATA_WIDTH  (DW)
  ) dut (
    .clock            (clk),
    .reset            (rst_n),
    .host_interface   (host_bus),
    .device_interface (dev_bus),
    .clear_error      (clear_error),
    .timeout_error    (timeout_error),
    .timeout_is_write (timeout_is_write),
    .timeout_index    (timeout_index)
  );

  int compared   = 0;
  int mismatched = 0;

  // Downstream responder: acks on the ack_after-th cycle of a req (0 = never).
  int          ack_after = 0;
  logic [DW-1:0] dev_rdata = '0;
  int          seen = 0;

  assign dev_bus.read_ack  = (ack_after > 0) && dev_bus.read_req  && (seen == ack_after - 1);
  assign dev_bus.write_ack = (ack_after > 0) && dev_bus.write_req && (seen == ack_after - 1);
  assign dev_bus.read_data = dev_rdata;

  always @(posedge clk) begin
    if (dev_bus.read_req || dev_bus.write_req) begin
      if (dev_bus.read_ack || dev_bus.write_ack) seen <= 0;
      else                                        seen <= seen + 1;
    end else begin
      seen <= 0;
    end
  end

  int   n_rack = 0, n_wack = 0, n_rissue = 0, n_wissue = 0;
  logic prev_rreq = 1'b0, prev_wreq = 1'b0;

  always @(negedge clk) begin
    if (host_bus.read_ack === 1'b1)  n_rack <= n_rack + 1;
    if (host_bus.write_ack === 1'b1) n_wack <= n_wack + 1;
    if (dev_bus.read_req === 1'b1 && !prev_rreq)  n_rissue <= n_rissue + 1;
    if (dev_bus.write_req === 1'b1 && !prev_wreq) n_wissue <= n_wissue + 1;
    prev_rreq <= (dev_bus.read_req === 1'b1);
    prev_wreq <= (dev_bus.write_req === 1'b1);
  end

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    compared++;
    if (dev_bus.read_req !== 1'b0 || dev_bus.write_req !== 1'b0) begin
      mismatched++;
      $display("FAIL reset_dev_req: got r=%b w=%b expected 0 0", dev_bus.read_req, dev_bus.write_req);
    end
    compared++;
    if (host_bus.read_ack !== 1'b0 || host_bus.write_ack !== 1'b0 || host_bus.read_data !== '0) begin
      mismatched++;
      $display("FAIL reset_host: got racks=%b wack=%b rdata=%h expected 0 0 0",
               host_bus.read_ack, host_bus.write_ack, host_bus.read_data);
    end
    compared++;
    if (timeout_error !== 1'b0 || timeout_is_write !== 1'b0 || timeout_index !== '0) begin
      mismatched++;
      $display("FAIL reset_err: got err=%b wr=%b idx=%h expected 0 0 0",
               timeout_error, timeout_is_write, timeout_index);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_read;
    int b_ack;
    b_ack = n_rack;
    ack_after = 1;
    dev_rdata = 32'h0000_1234;
    host_bus.read_req   = 1'b1;
    host_bus.read_index = 16'd5;
    @(negedge clk);
    compared++;
    if (dev_bus.read_req !== 1'b1 || dev_bus.read_index !== 16'd5 || host_bus.read_ack !== 1'b0) begin
      mismatched++;
      $display("FAIL read_issue: got req=%b idx=%h ack=%b expected 1 0005 0",
               dev_bus.read_req, dev_bus.read_index, host_bus.read_ack);
    end
    @(negedge clk);
    compared++;
    if (host_bus.read_ack !== 1'b1 || host_bus.read_data !== 32'h0000_1234 || dev_bus.read_req !== 1'b0) begin
      mismatched++;
      $display("FAIL read_ack: got ack=%b data=%h devreq=%b expected 1 00001234 0",
               host_bus.read_ack, host_bus.read_data, dev_bus.read_req);
    end
    host_bus.read_req = 1'b0;
    @(negedge clk);
    compared++;
    if (host_bus.read_ack !== 1'b0 || host_bus.read_data !== 32'h0000_1234 || timeout_error !== 1'b0) begin
      mismatched++;
      $display("FAIL read_after: got ack=%b data=%h err=%b expected 0 00001234 0",
               host_bus.read_ack, host_bus.read_data, timeout_error);
    end
    repeat (2) @(negedge clk);
    compared++;
    if (n_rack - b_ack !== 1) begin
      mismatched++;
      $display("FAIL read_ack_count: got %0d expected 1", n_rack - b_ack);
    end
  endtask

  task automatic test_write;
    int b_ack, b_iss;
    b_ack = n_wack;
    b_iss = n_wissue;
    ack_after = 3;
    host_bus.write_req   = 1'b1;
    host_bus.write_index = 16'h0040;
    host_bus.write_data  = 32'h0000_A5A5;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      compared++;
      if (dev_bus.write_req !== 1'b1 || dev_bus.write_index !== 16'h0040 ||
          dev_bus.write_data !== 32'h0000_A5A5 || dev_bus.read_req !== 1'b0 ||
          host_bus.write_ack !== 1'b0) begin
        mismatched++;
        $display("FAIL write_wait%0d: got wreq=%b idx=%h data=%h rreq=%b ack=%b expected 1 0040 0000a5a5 0 0",
                 i, dev_bus.write_req, dev_bus.write_index, dev_bus.write_data,
                 dev_bus.read_req, host_bus.write_ack);
      end
    end
    @(negedge clk);
    compared++;
    if (host_bus.write_ack !== 1'b1 || dev_bus.write_req !== 1'b0) begin
      mismatched++;
      $display("FAIL write_respond: got ack=%b devreq=%b expected 1 0",
               host_bus.write_ack, dev_bus.write_req);
    end
    host_bus.write_req = 1'b0;
    repeat (3) @(negedge clk);
    compared++;
    if (n_wack - b_ack !== 1 || n_wissue - b_iss !== 1) begin
      mismatched++;
      $display("FAIL write_counts: got acks=%0d issues=%0d expected 1 1",
               n_wack - b_ack, n_wissue - b_iss);
    end
  endtask

  task automatic test_timeout_read;
    ack_after = 0;
    host_bus.read_req   = 1'b1;
    host_bus.read_index = 16'h03FF;
    for (int i = 0; i < TO; i++) begin
      @(negedge clk);
      compared++;
      if (host_bus.read_ack !== 1'b0 || timeout_error !== 1'b0) begin
        mismatched++;
        $display("FAIL tmo_read_early%0d: got ack=%b err=%b expected 0 0", i, host_bus.read_ack, timeout_error);
      end
    end
    @(negedge clk);
    compared++;
    if (host_bus.read_ack !== 1'b1 || host_bus.read_data !== 32'hDEAD_BEEF) begin
      mismatched++;
      $display("FAIL tmo_read_ack: got ack=%b data=%h expected 1 deadbeef", host_bus.read_ack, host_bus.read_data);
    end
    compared++;
    if (timeout_error !== 1'b1 || timeout_index !== 16'h03FF || timeout_is_write !== 1'b0) begin
      mismatched++;
      $display("FAIL tmo_read_log: got err=%b idx=%h wr=%b expected 1 03ff 0",
               timeout_error, timeout_index, timeout_is_write);
    end
    host_bus.read_req = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_timeout_write_clear;
    ack_after = 0;
    host_bus.write_req   = 1'b1;
    host_bus.write_index = 16'h0012;
    host_bus.write_data  = 32'h0000_0001;
    for (int i = 0; i < TO; i++) begin
      @(negedge clk);
      compared++;
      if (timeout_error !== 1'b1 || host_bus.write_ack !== 1'b0) begin
        mismatched++;
        $display("FAIL tmo_write_early%0d: got err=%b ack=%b expected 1 0", i, timeout_error, host_bus.write_ack);
      end
      if (i == TO - 1) clear_error = 1'b1;
    end
    @(negedge clk);
    clear_error = 1'b0;
    compared++;
    if (host_bus.write_ack !== 1'b1 || timeout_error !== 1'b1 ||
        timeout_index !== 16'h0012 || timeout_is_write !== 1'b1) begin
      mismatched++;
      $display("FAIL tmo_write_precedence: got ack=%b err=%b idx=%h wr=%b expected 1 1 0012 1",
               host_bus.write_ack, timeout_error, timeout_index, timeout_is_write);
    end
    compared++;
    if (host_bus.read_data !== 32'hDEAD_BEEF) begin
      mismatched++;
      $display("FAIL tmo_write_rdata: got %h expected deadbeef", host_bus.read_data);
    end
    host_bus.write_req = 1'b0;
    @(negedge clk);
    clear_error = 1'b1;
    @(negedge clk);
    clear_error = 1'b0;
    compared++;
    if (timeout_error !== 1'b0 || timeout_index !== 16'h0012) begin
      mismatched++;
      $display("FAIL clear_error: got err=%b idx=%h expected 0 0012", timeout_error, timeout_index);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_both;
    int  b_rack, b_wack, b_ri, b_wi;
    bit  got_w;
    b_rack = n_rack;  b_wack = n_wack;
    b_ri   = n_rissue; b_wi  = n_wissue;
    got_w = 1'b0;
    ack_after = 1;
    dev_rdata = 32'h0000_0BAD;
    host_bus.read_req    = 1'b1;
    host_bus.read_index  = 16'h0001;
    host_bus.write_req   = 1'b1;
    host_bus.write_index = 16'h0002;
    host_bus.write_data  = 32'h0000_0077;
    @(negedge clk);
    compared++;
    if (dev_bus.read_req !== 1'b1 || dev_bus.write_req !== 1'b0) begin
      mismatched++;
      $display("FAIL both_order: got rreq=%b wreq=%b expected 1 0", dev_bus.read_req, dev_bus.write_req);
    end
    @(negedge clk);
    compared++;
    if (host_bus.read_ack !== 1'b1 || host_bus.write_ack !== 1'b0 || host_bus.read_data !== 32'h0000_0BAD) begin
      mismatched++;
      $display("FAIL both_read_ack: got rack=%b wack=%b data=%h expected 1 0 00000bad",
               host_bus.read_ack, host_bus.write_ack, host_bus.read_data);
    end
    host_bus.read_req = 1'b0;
    for (int i = 0; i < 12 && !got_w; i++) begin
      @(negedge clk);
      if (host_bus.write_ack === 1'b1) begin
        got_w = 1'b1;
        host_bus.write_req = 1'b0;
      end
    end
    host_bus.write_req = 1'b0;
    compared++;
    if (!got_w) begin
      mismatched++;
      $display("FAIL both_write_ack: got none within 12 cycles expected 1");
    end
    repeat (3) @(negedge clk);
    compared++;
    if (n_rack - b_rack !== 1 || n_wack - b_wack !== 1 || n_rissue - b_ri !== 1 || n_wissue - b_wi !== 1) begin
      mismatched++;
      $display("FAIL both_counts: got rack=%0d wack=%0d ri=%0d wi=%0d expected 1 1 1 1",
               n_rack - b_rack, n_wack - b_wack, n_rissue - b_ri, n_wissue - b_wi);
    end
  endtask

  task automatic test_held_req;
    int b_ack, b_iss;
    b_ack = n_rack;
    b_iss = n_rissue;
    ack_after = 1;
    dev_rdata = 32'h0000_CAFE;
    host_bus.read_req   = 1'b1;
    host_bus.read_index = 16'h0009;
    repeat (2) @(negedge clk);
    compared++;
    if (host_bus.read_ack !== 1'b1 || host_bus.read_data !== 32'h0000_CAFE) begin
      mismatched++;
      $display("FAIL held_first_ack: got ack=%b data=%h expected 1 0000cafe", host_bus.read_ack, host_bus.read_data);
    end
    repeat (6) @(negedge clk);
    host_bus.read_req = 1'b0;
    repeat (3) @(negedge clk);
    compared++;
    if (n_rack - b_ack !== 1 || n_rissue - b_iss !== 1) begin
      mismatched++;
      $display("FAIL held_counts: got acks=%0d issues=%0d expected 1 1", n_rack - b_ack, n_rissue - b_iss);
    end
  endtask

  task automatic test_reset_mid;
    int b_ack;
    b_ack = n_rack;
    ack_after = 0;
    host_bus.read_req   = 1'b1;
    host_bus.read_index = 16'h0021;
    repeat (2) @(negedge clk);
    compared++;
    if (dev_bus.read_req !== 1'b1) begin
      mismatched++;
      $display("FAIL rstmid_wait: got devreq=%b expected 1", dev_bus.read_req);
    end
    rst_n = 1'b0;
    host_bus.read_req = 1'b0;
    @(negedge clk);
    compared++;
    if (dev_bus.read_req !== 1'b0 || host_bus.read_ack !== 1'b0 || host_bus.read_data !== '0) begin
      mismatched++;
      $display("FAIL rstmid_abandon: got devreq=%b ack=%b data=%h expected 0 0 0",
               dev_bus.read_req, host_bus.read_ack, host_bus.read_data);
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    compared++;
    if (n_rack - b_ack !== 0) begin
      mismatched++;
      $display("FAIL rstmid_no_ack: got %0d acks expected 0", n_rack - b_ack);
    end
    ack_after = 1;
    dev_rdata = 32'h0000_BEEF;
    host_bus.read_req   = 1'b1;
    host_bus.read_index = 16'h0007;
    @(negedge clk);
    compared++;
    if (dev_bus.read_req !== 1'b1 || dev_bus.read_index !== 16'h0007) begin
      mismatched++;
      $display("FAIL rstmid_reissue: got req=%b idx=%h expected 1 0007", dev_bus.read_req, dev_bus.read_index);
    end
    @(negedge clk);
    compared++;
    if (host_bus.read_ack !== 1'b1 || host_bus.read_data !== 32'h0000_BEEF) begin
      mismatched++;
      $display("FAIL rstmid_read: got ack=%b data=%h expected 1 0000beef", host_bus.read_ack, host_bus.read_data);
    end
    host_bus.read_req = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  initial begin
    host_bus.read_req    = 1'b0;
    host_bus.read_index  = '0;
    host_bus.write_req   = 1'b0;
    host_bus.write_index = '0;
    host_bus.write_data  = '0;
    test_reset();
    test_read();
    test_write();
    test_timeout_read();
    test_timeout_write_clear();
    test_both();
    test_held_req();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
